// File: rtl/lvt_hash_client.sv
// Per-port request engine for the multi-ported LVT hash table.
// Hashes a key to a slot, linear-probes on collision, writes on insert, returns hit/miss/full.
module lvt_hash_client #(
    parameter int index_width  = 4,
    parameter int key_width    = 8,
    parameter int value_width  = 8,
    parameter int read_latency = 2,
    parameter int max_probe    = 4,
    localparam int data_width  = 1 + key_width + value_width
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   cmd_valid,
    output logic                   cmd_ready,
    input  logic                   cmd_op,
    input  logic [key_width-1:0]   cmd_key,
    input  logic [value_width-1:0] cmd_value,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic                   rsp_hit,
    output logic                   rsp_full,
    output logic [value_width-1:0] rsp_value,
    output logic [index_width-1:0] addr,
    output logic                   ren,
    output logic                   wen,
    output logic [data_width-1:0]  write_data,
    input  logic [data_width-1:0]  read_data
);
    // state  | meaning
    // IDLE   | waiting for a command
    // READ   | ren for the current slot
    // WAIT   | counting down the table read latency
    // EVAL   | read_data valid, compare slot against key
    // WRITE  | wen with {1, key, value}
    // RESP   | hold response until rsp_ready
    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_READ  = 3'd1;
    localparam logic [2:0] S_WAIT  = 3'd2;
    localparam logic [2:0] S_EVAL  = 3'd3;
    localparam logic [2:0] S_WRITE = 3'd4;
    localparam logic [2:0] S_RESP  = 3'd5;

    localparam int num_slices = (key_width + index_width - 1) / index_width;
    localparam int pad_width  = num_slices * index_width;
    localparam int probe_w    = $clog2(max_probe + 1);
    localparam int wait_w     = (read_latency > 2) ? $clog2(read_latency - 1) : 1;
    localparam int wait_init  = (read_latency > 1) ? read_latency - 2 : 0;
    localparam logic [probe_w-1:0] probe_last = probe_w'(max_probe - 1);
    localparam logic [wait_w-1:0]  wait_load  = wait_w'(wait_init);

    logic [2:0]             state_q, state_d;
    logic                   armed_q, armed_d;
    logic                   op_q, op_d;
    logic [key_width-1:0]   key_q, key_d;
    logic [value_width-1:0] value_q, value_d;
    logic [index_width-1:0] slot_q, slot_d;
    logic [probe_w-1:0]     probe_q, probe_d;
    logic [wait_w-1:0]      wait_q, wait_d;
    logic                   hit_q, hit_d;
    logic                   full_q, full_d;
    logic [value_width-1:0] rval_q, rval_d;

    logic [pad_width-1:0]   key_pad;
    logic [index_width-1:0] hash_idx;
    logic                   rd_valid;
    logic [key_width-1:0]   rd_key;
    logic [value_width-1:0] rd_value;

    // Zero-padded key folded by XOR of index-width slices, LSB slice first.
    always_comb begin
        key_pad  = pad_width'(cmd_key);
        hash_idx = '0;
        for (int i = 0; i < num_slices; i++) begin
            hash_idx = hash_idx ^ key_pad[i*index_width +: index_width];
        end
    end

    assign rd_valid = read_data[data_width-1];
    assign rd_key   = read_data[key_width+value_width-1 -: key_width];
    assign rd_value = read_data[value_width-1:0];

    always_comb begin
        state_d = state_q;
        armed_d = 1'b1;
        op_d    = op_q;
        key_d   = key_q;
        value_d = value_q;
        slot_d  = slot_q;
        probe_d = probe_q;
        wait_d  = wait_q;
        hit_d   = hit_q;
        full_d  = full_q;
        rval_d  = rval_q;
        case (state_q)
            S_IDLE: begin
                if (cmd_valid && armed_q) begin
                    op_d    = cmd_op;
                    key_d   = cmd_key;
                    value_d = cmd_value;
                    slot_d  = hash_idx;
                    probe_d = '0;
                    hit_d   = 1'b0;
                    full_d  = 1'b0;
                    rval_d  = '0;
                    state_d = S_READ;
                end
            end
            S_READ: begin
                wait_d = wait_load;
                if (read_latency == 1) state_d = S_EVAL;
                else                   state_d = S_WAIT;
            end
            S_WAIT: begin
                if (wait_q == '0) state_d = S_EVAL;
                else              wait_d  = wait_q - 1'b1;
            end
            S_EVAL: begin
                if (rd_valid && rd_key == key_q) begin
                    hit_d   = 1'b1;
                    rval_d  = op_q ? value_q : rd_value;
                    state_d = op_q ? S_WRITE : S_RESP;
                end else if (!rd_valid) begin
                    hit_d   = 1'b0;
                    rval_d  = op_q ? value_q : '0;
                    state_d = op_q ? S_WRITE : S_RESP;
                end else if (probe_q < probe_last) begin
                    probe_d = probe_q + 1'b1;
                    slot_d  = slot_q + 1'b1;
                    state_d = S_READ;
                end else begin
                    // Probe budget spent on foreign keys: miss for lookup, full for insert.
                    full_d  = op_q;
                    rval_d  = '0;
                    state_d = S_RESP;
                end
            end
            S_WRITE: state_d = S_RESP;
            S_RESP:  if (rsp_ready) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            armed_q <= 1'b0;
            op_q    <= 1'b0;
            key_q   <= '0;
            value_q <= '0;
            slot_q  <= '0;
            probe_q <= '0;
            wait_q  <= '0;
            hit_q   <= 1'b0;
            full_q  <= 1'b0;
            rval_q  <= '0;
        end else begin
            state_q <= state_d;
            armed_q <= armed_d;
            op_q    <= op_d;
            key_q   <= key_d;
            value_q <= value_d;
            slot_q  <= slot_d;
            probe_q <= probe_d;
            wait_q  <= wait_d;
            hit_q   <= hit_d;
            full_q  <= full_d;
            rval_q  <= rval_d;
        end
    end

    // armed_q keeps cmd_ready low until the first edge after reset releases.
    assign cmd_ready  = (state_q == S_IDLE) && armed_q;
    assign ren        = (state_q == S_READ);
    assign wen        = (state_q == S_WRITE);
    assign addr       = (ren || wen) ? slot_q : '0;
    assign write_data = wen ? {1'b1, key_q, value_q} : '0;
    assign rsp_valid  = (state_q == S_RESP);
    assign rsp_hit    = rsp_valid & hit_q;
    assign rsp_full   = rsp_valid & full_q;
    assign rsp_value  = rsp_valid ? rval_q : '0;

endmodule
